prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of the first loaded word.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_valid  input  1  upstream byte available.
REQ-006 SHALL have port rx_data  input  8  upstream byte.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  32  word-aligned byte address of the write.
REQ-010 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_reset  output  1  holds the processor core in reset while high.
REQ-012 SHALL have port done  output  1  load completed successfully (sticky).
REQ-013 SHALL have port error  output  1  load aborted (sticky).

Function
REQ-014 SHALL accept a byte only on a rising edge where rx_valid and rx_ready are both 1; all other cycles are ignored.
REQ-015 SHALL implement states S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR.
REQ-016 SHALL accept the stream format: length low byte, length high byte (word count N, 16 bit), then N words, each sent as 4 bytes, least significant byte first.
REQ-017 S_LEN0 -> S_LEN1 on the first accepted byte; S_LEN1 -> S_DATA on the second accepted byte when 0 < N <= MAX_WORDS.
REQ-018 S_LEN1 -> S_ERR when N > MAX_WORDS; S_LEN1 -> end-of-data transition (REQ-021) when N == 0.
REQ-019 In S_DATA, on the 4th byte of word k, imem_we SHALL pulse high for exactly the following cycle, with imem_addr = BASE_ADDR + 4*k and the assembled word on imem_wdata (1-cycle latency).
REQ-020 imem_addr/imem_wdata SHALL hold their last values when imem_we is 0; the word index SHALL not wrap (bounded by REQ-018).
REQ-021 After word N-1 is accepted (or N == 0), the FSM SHALL go to S_DONE, or to S_CSUM when the checksum feature is enabled (REQ-030).
REQ-022 rx_ready SHALL be 1 in S_LEN0, S_LEN1, S_DATA, S_CSUM and 0 in S_DONE and S_ERR.
REQ-023 done SHALL be 1 exactly in S_DONE; error SHALL be 1 exactly in S_ERR; both states are exited only by reset.
REQ-024 cpu_reset SHALL equal NOT done (registered), so the core leaves reset the cycle done rises and only after the last imem_we has completed.
REQ-025 rx_data changes while rx_valid is 1 and rx_ready is 0 SHALL have no effect.

Reset
REQ-026 While reset is 1: state = S_LEN0, word index = 0, byte count = 0, imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0, done = 0, error = 0, cpu_reset = 1, rx_ready = 0.
REQ-027 Reset asserted mid-load SHALL discard any partially assembled word and suppress any pending imem_we; memory contents already written are not cleared.
REQ-028 The first cycle after reset deasserts SHALL have rx_ready = 1 and accept a length byte.

Configuration
REQ-029 Macro PROG_LOADER_CHECKSUM_EN SHALL compile in the checksum feature.
REQ-030 With it defined: one extra byte SHALL follow the data; it must equal the XOR of all previous bytes of the stream (length bytes included); match -> S_DONE, mismatch -> S_ERR.
REQ-031 Without it: S_CSUM and its logic SHALL be absent; the FSM goes directly to S_DONE.

Structure
REQ-032 Package prog_loader_pkg SHALL hold the state enum typedef and constants (BYTES_PER_WORD = 4, LEN_BYTES = 2).
REQ-033 Sub-module byte_packer SHALL shift accepted bytes into a 32-bit word and flag the 4th byte.

Verification
REQ-034 Stream 02 00 13 05 A0 00 93 05 B0 00 -> imem_we pulses with addr 0x0/data 0x00A00513, then addr 0x4/data 0x00B00593; done = 1, cpu_reset = 0.
REQ-035 Same stream with rx_valid low every other cycle -> identical writes and done; no duplicated write.
REQ-036 Stream 00 00 (checksum off) -> done = 1 with no imem_we; stream 01 01 (N = 257 > 256) -> error = 1, rx_ready = 0, cpu_reset stays 1.
REQ-037 Reset pulsed after 02 00 13 05 -> no imem_we; a following full REQ-034 stream writes from addr 0x0 again.
REQ-038 With PROG_LOADER_CHECKSUM_EN: REQ-034 stream plus 0x92 -> done = 1; plus 0x93 -> error = 1, both words still written.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// PROG_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and its state.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Running XOR over every accepted stream byte.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words and flags the last byte of each word.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);

  localparam logic [1:0] LAST_CNT = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_r;
  logic [23:0] shift_r;

  assign word = {din, shift_r};
  assign last = en && (cnt_r == LAST_CNT);

  // Byte counter and shift register for the three bytes already received.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (en) begin
      cnt_r   <= cnt_r + 2'd1;
      shift_r <= {din, shift_r[23:8]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: length-prefixed byte stream into instruction memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CSUM;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t      state_r, state_s;
  logic [7:0]  len_lo_r;
  logic [15:0] len_r;
  logic [15:0] word_idx_r;
  logic [15:0] len_s;
  logic        ready_s, accept_s, last_word_s;
  logic        pk_en_s, pk_last_s;
  logic [31:0] pk_word_s;
  logic        imem_we_r, cpu_reset_r, done_r, error_r;
  logic [31:0] imem_addr_r, imem_wdata_r;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;
`endif

  // Ready is gated by reset so nothing is taken while reset is held.
  always_comb begin
    ready_s = 1'b0;
    if (reset) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        S_LEN0, S_LEN1, S_DATA: ready_s = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM:                 ready_s = 1'b1;
`endif
        default:                ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s    = rx_valid && ready_s;
  assign len_s       = {rx_data, len_lo_r};
  assign pk_en_s     = accept_s && (state_r == S_DATA);
  assign last_word_s = (word_idx_r == (len_r - 16'd1));

  byte_packer u_packer (
    .clk   (CLK),
    .reset (reset),
    .en    (pk_en_s),
    .din   (rx_data),
    .word  (pk_word_s),
    .last  (pk_last_s)
  );

  // Next-state logic; unknown encodings fall into the error trap.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_LEN0: begin
        if (accept_s) state_s = S_LEN1;
        else          state_s = state_r;
      end
      S_LEN1: begin
        if (!accept_s)                 state_s = state_r;
        else if (len_s == 16'd0)       state_s = END_STATE;
        else if ({1'b0, len_s} > MAX_N) state_s = S_ERR;
        else                           state_s = S_DATA;
      end
      S_DATA: begin
        if (pk_last_s && last_word_s) state_s = END_STATE;
        else                          state_s = state_r;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (!accept_s)             state_s = state_r;
        else if (csum_r == rx_data) state_s = S_DONE;
        else                       state_s = S_ERR;
      end
`endif
      S_DONE:  state_s = S_DONE;
      S_ERR:   state_s = S_ERR;
      default: state_s = S_ERR;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state_r <= S_LEN0;
    else       state_r <= state_s;
  end

  // Length capture, write strobe and status flags, all aligned with the state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      len_lo_r     <= 8'd0;
      len_r        <= 16'd0;
      word_idx_r   <= 16'd0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= BASE_ADDR;
      imem_wdata_r <= 32'd0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      cpu_reset_r  <= 1'b1;
    end else begin
      imem_we_r <= 1'b0;
      if (accept_s && (state_r == S_LEN0)) len_lo_r <= rx_data;
      if (accept_s && (state_r == S_LEN1)) len_r    <= len_s;
      if (pk_last_s) begin
        imem_we_r    <= 1'b1;
        imem_addr_r  <= BASE_ADDR + {14'd0, word_idx_r, 2'b00};
        imem_wdata_r <= pk_word_s;
        word_idx_r   <= word_idx_r + 16'd1;
      end
      done_r      <= (state_s == S_DONE);
      error_r     <= (state_s == S_ERR);
      cpu_reset_r <= (state_s != S_DONE);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Checksum accumulator over length and data bytes.
  always_ff @(posedge CLK) begin
    if (reset)         csum_r <= 8'd0;
    else if (accept_s) csum_r <= csum_next(csum_r, rx_data);
  end
`endif

  assign rx_ready   = ready_s;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_reset  = cpu_reset_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued as bytes are driven.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, imem_we, cpu_reset, done, error;
  logic [31:0] imem_addr, imem_wdata;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_wr  = 0;
  int         wr0;
  logic [7:0] xr = 8'd0;
  logic       prev_we = 1'b0;

  prog_loader #(.MAX_WORDS(256), .BASE_ADDR(BASE)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every write strobe is matched against the oldest expected write.
  always @(negedge CLK) begin
    wr_t e;
    if (imem_we) begin
      n_wr++;
      check("we_pulse", {31'd0, prev_we}, 32'd0);
      if (sb.size() != 0) e = sb.pop_front();
      else                e = '{addr: 32'hDEAD_DEAD, data: 32'hDEAD_DEAD};
      check("wr_addr", imem_addr, e.addr);
      check("wr_data", imem_wdata, e.data);
    end
    prev_we <= imem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge CLK);
    check("rx_ready_before_byte", {31'd0, rx_ready}, 32'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    xr       = xr ^ b;
    @(negedge CLK);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_len(input logic [15:0] n, input int gap);
    xr = 8'd0;
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic send_word(input int k, input logic [31:0] w, input int gap);
    sb.push_back('{addr: BASE + 32'(k) * 32'd4, data: w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_csum(input int gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(xr, gap);
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    reset = 1'b0;
    #1;
    check("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic example_stream(input int gap);
    send_len(16'd2, gap);
    send_word(0, 32'h00A0_0513, gap);
    send_word(1, 32'h00B0_0593, gap);
  endtask

  task automatic expect_done(input string tag, input int writes);
    repeat (2) @(negedge CLK);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_writes"}, 32'(n_wr - wr0), 32'(writes));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    wr0 = n_wr;
    example_stream(0);
    send_csum(0);
    expect_done("basic", 2);
    check("hold_addr", imem_addr, 32'h0000_0004);
    check("hold_wdata", imem_wdata, 32'h00B0_0593);

    // Bytes offered while done must be ignored.
    wr0 = n_wr;
    @(negedge CLK);
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'($urandom);
      @(negedge CLK);
    end
    rx_valid = 1'b0;
    check("ignore_writes", 32'(n_wr - wr0), 32'd0);
    check("ignore_done", {31'd0, done}, 32'd1);
    check("ignore_wdata", imem_wdata, 32'h00B0_0593);

    do_reset();
    wr0 = n_wr;
    example_stream(1);
    send_csum(1);
    expect_done("gapped", 2);

    do_reset();
    wr0 = n_wr;
    send_len(16'd0, 0);
    send_csum(0);
    expect_done("zero_len", 0);

    do_reset();
    wr0 = n_wr;
    send_len(16'h0101, 0);
    repeat (2) @(negedge CLK);
    check("over_error", {31'd0, error}, 32'd1);
    check("over_done", {31'd0, done}, 32'd0);
    check("over_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("over_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("over_writes", 32'(n_wr - wr0), 32'd0);

    // Partial word discarded by reset, then a full reload starts at the base.
    do_reset();
    wr0 = n_wr;
    send_len(16'd2, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    do_reset();
    check("midrst_writes", 32'(n_wr - wr0), 32'd0);
    example_stream(0);
    send_csum(0);
    expect_done("reload", 2);

    do_reset();
    wr0 = n_wr;
    send_len(16'd256, 0);
    for (int k = 0; k < 256; k++) send_word(k, $urandom, 0);
    send_csum(0);
    expect_done("max_len", 256);
    check("max_last_addr", imem_addr, BASE + 32'h0000_03FC);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    wr0 = n_wr;
    example_stream(0);
    check("csum_value", {24'd0, xr}, 32'h0000_0092);
    send_byte(xr ^ 8'h01, 0);
    repeat (2) @(negedge CLK);
    check("badcsum_error", {31'd0, error}, 32'd1);
    check("badcsum_done", {31'd0, done}, 32'd0);
    check("badcsum_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("badcsum_writes", 32'(n_wr - wr0), 32'd2);
`endif

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
